// File: rtl/reg_dump_monitor_if.sv
// Register dump stream: one beat per register, valid/ready handshake.
interface reg_dump_monitor_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] data;

  modport master (output valid, idx, data, input ready);
  modport slave  (input valid, idx, data, output ready);
endinterface

// File: rtl/reg_dump_monitor.sv
// Run monitor for the single-cycle MIPS core: detects end of program and
// then streams the whole register file out through the dump interface.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start after reset
// RUN    | CPU running; watching PC for end address, stall, watchdog
// READ   | presenting idx on the spare register-file read port
// SEND   | beat held on the dump port until the sink accepts it
// DONE   | dump complete; results held until the next start
module reg_dump_monitor #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int PC_W        = 32,
  parameter int STALL_LIMIT = 8,
  parameter int MAX_CYCLES  = 1230
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PC_W-1:0]      pc,
  input  logic [PC_W-1:0]      end_pc,
  input  logic                 end_pc_en,
  output logic [ADDR_W-1:0]    rf_raddr,
  input  logic [DATA_W-1:0]    rf_rdata,
  reg_dump_monitor_if.master   dump,
  output logic [PC_W-1:0]      final_pc,
  output logic [1:0]           halt_cause,
  output logic [31:0]          cycle_count,
  output logic                 busy,
  output logic                 done
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);
  localparam logic [31:0]       STALL_LAST = 32'(STALL_LIMIT - 1);
  localparam logic [31:0]       WD_LAST    = 32'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PC_W-1:0]   pc_q;
  logic [31:0]       stall_cnt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] dump_idx_q;
  logic [DATA_W-1:0] dump_data_q;

  logic              pc_same;
  logic              end_hit;
  logic              stall_hit;
  logic              wd_hit;
  logic              halt;
  logic [1:0]        cause;

  // Halt detection on this cycle's PC; earlier conditions win.
  always_comb begin
    pc_same   = (pc == pc_q);
    end_hit   = end_pc_en && (pc == end_pc);
    stall_hit = pc_same && (stall_cnt == STALL_LAST);
    wd_hit    = (cycle_count == WD_LAST);
    halt      = (state == S_RUN) && (end_hit || stall_hit || wd_hit);
    if (end_hit) begin
      cause = 2'd1;
    end else if (stall_hit) begin
      cause = 2'd2;
    end else if (wd_hit) begin
      cause = 2'd3;
    end else begin
      cause = 2'd0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
      S_RUN:          if (halt) state_nxt = S_READ;
      S_READ:         state_nxt = S_SEND;
      S_SEND: begin
        if (dump.ready) begin
          state_nxt = (idx == LAST_IDX) ? S_DONE : S_READ;
        end
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs; the read port is parked at 0 except during READ.
  always_comb begin
    busy       = (state == S_RUN) || (state == S_READ) || (state == S_SEND);
    done       = (state == S_DONE);
    rf_raddr   = (state == S_READ) ? idx : '0;
    dump.valid = (state == S_SEND);
    dump.idx   = dump_idx_q;
    dump.data  = dump_data_q;
  end

  // Counters, PC history, halt results and the captured dump beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      stall_cnt   <= '0;
      cycle_count <= '0;
      final_pc    <= '0;
      halt_cause  <= '0;
      idx         <= '0;
      dump_idx_q  <= '0;
      dump_data_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc_q        <= pc;
            stall_cnt   <= '0;
            cycle_count <= '0;
            final_pc    <= '0;
            halt_cause  <= '0;
            idx         <= '0;
          end
        end
        S_RUN: begin
          pc_q        <= pc;
          stall_cnt   <= pc_same ? stall_cnt + 32'd1 : 32'd0;
          cycle_count <= cycle_count + 32'd1;
          if (halt) begin
            final_pc   <= pc;
            halt_cause <= cause;
            idx        <= '0;
          end
        end
        S_READ: begin
          dump_data_q <= rf_rdata;
          dump_idx_q  <= idx;
        end
        S_SEND: begin
          // idx stops at the last register; DONE follows its handshake.
          if (dump.ready && (idx != LAST_IDX)) begin
            idx <= idx + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_monitor.sv
// Scoreboard bench for reg_dump_monitor: the driver pushes expected beats and
// halt summaries, a negedge monitor pops and compares them as the DUT emits.
module tb_reg_dump_monitor;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 5;
  localparam int PC_W        = 32;
  localparam int NUM_REGS    = 32;
  localparam int STALL_LIMIT = 8;
  localparam int MAX_CYCLES  = 1230;

  typedef struct {
    logic [31:0] fpc;
    logic [1:0]  cause;
    logic [31:0] cc;
  } summ_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   end_pc;
  logic              end_pc_en;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic [PC_W-1:0]   final_pc;
  logic [1:0]        halt_cause;
  logic [31:0]       cycle_count;
  logic              busy;
  logic              done;

  reg_dump_monitor_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dump_bus ();

  logic [DATA_W-1:0] rf_mem [NUM_REGS];
  assign rf_rdata = rf_mem[rf_raddr];

  always #5 clk = ~clk;

  reg_dump_monitor #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W),
    .STALL_LIMIT(STALL_LIMIT), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .end_pc(end_pc),
    .end_pc_en(end_pc_en), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dump(dump_bus), .final_pc(final_pc), .halt_cause(halt_cause),
    .cycle_count(cycle_count), .busy(busy), .done(done)
  );

  int errors = 0;
  int checks = 0;
  int beats_seen = 0;
  logic [ADDR_W+DATA_W-1:0] beat_q[$];
  summ_t summ_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: beat scoreboard, hold-while-stalled check, halt summary on done rise.
  logic              prev_stall = 1'b0;
  logic              prev_done  = 1'b0;
  logic [ADDR_W-1:0] held_idx;
  logic [DATA_W-1:0] held_data;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (dump_bus.valid) begin
        check("raddr_parked", rf_raddr, 0);
        if (prev_stall) begin
          check("hold_idx", dump_bus.idx, held_idx);
          check("hold_data", dump_bus.data, held_data);
        end
      end
      if (dump_bus.valid && dump_bus.ready) begin
        if (beat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got idx %0d, none expected", dump_bus.idx);
        end else begin
          logic [ADDR_W+DATA_W-1:0] e;
          e = beat_q.pop_front();
          check("beat_idx", dump_bus.idx, e[ADDR_W+DATA_W-1:DATA_W]);
          check("beat_data", dump_bus.data, e[DATA_W-1:0]);
        end
        beats_seen++;
      end
      prev_stall = dump_bus.valid && !dump_bus.ready;
      held_idx   = dump_bus.idx;
      held_data  = dump_bus.data;
      if (done && !prev_done) begin
        if (summ_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done, none expected");
        end else begin
          summ_t s;
          s = summ_q.pop_front();
          check("final_pc", final_pc, s.fpc);
          check("halt_cause", halt_cause, s.cause);
          check("cycle_count", cycle_count, s.cc);
        end
      end
      prev_done = done;
    end
  end

  function automatic logic [31:0] pc_of(input int m, input int n);
    if (m == 0) return 32'(n * 4);
    return (n < 7) ? 32'(n * 4) : 32'h1C;
  endfunction

  function automatic logic en_of(input int e, input int n);
    if (e == 0) return 1'b0;
    if (e == 1) return 1'b1;
    return (n == 15);
  endfunction

  task automatic arm(input int seed, input logic [31:0] fpc, input logic [1:0] cause,
                     input logic [31:0] cc);
    summ_t s;
    for (int i = 0; i < NUM_REGS; i++) begin
      rf_mem[i] = {8'(seed), 8'(i), 8'(~i), 8'(seed * 3 + i)};
      beat_q.push_back({ADDR_W'(i), rf_mem[i]});
    end
    s.fpc = fpc;
    s.cause = cause;
    s.cc = cc;
    summ_q.push_back(s);
    beats_seen = 0;
  endtask

  // rmode: 0 ready high, 1 backpressure on beat 3 then random, 2 reset during beat 10
  task automatic run(input int m, input int e, input logic [31:0] epc, input int rmode,
                     input int max_edges, output int fv_n, output int done_n);
    int n;
    int bp;
    logic aborted;
    pc = pc_of(m, 0);
    end_pc = epc;
    end_pc_en = en_of(e, 0);
    dump_bus.ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    bp = 0;
    fv_n = -1;
    done_n = -1;
    aborted = 1'b0;
    check("run_busy", busy, 1);
    check("run_done_low", done, 0);
    check("run_cc_clear", cycle_count, 0);
    check("run_cause_clear", halt_cause, 0);
    check("run_fpc_clear", final_pc, 0);
    while (done_n < 0 && !aborted && n < max_edges) begin
      @(posedge clk);
      #1;
      n++;
      pc = pc_of(m, n);
      end_pc_en = en_of(e, n);
      if (dump_bus.valid && fv_n < 0) fv_n = n;
      if (done && done_n < 0) done_n = n;
      if (rmode == 1) begin
        if (dump_bus.valid && dump_bus.idx == 5'd3 && bp < 5) begin
          dump_bus.ready = 1'b0;
          bp++;
        end else if (bp >= 5) begin
          dump_bus.ready = 1'($urandom_range(0, 1));
        end else begin
          dump_bus.ready = 1'b1;
        end
      end else if (rmode == 2 && dump_bus.valid && dump_bus.idx == 5'd10) begin
        dump_bus.ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid_low", dump_bus.valid, 0);
        check("rst_busy_low", busy, 0);
        check("rst_done_low", done, 0);
        check("rst_cc", cycle_count, 0);
        check("rst_fpc", final_pc, 0);
        aborted = 1'b1;
      end
    end
    if (done_n < 0 && !aborted) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done within %0d cycles, required done", max_edges);
    end
    dump_bus.ready = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic end_of_dump(input string name);
    check({name, "_beats"}, beats_seen, NUM_REGS);
    check({name, "_beatq_empty"}, beat_q.size(), 0);
    check({name, "_summq_empty"}, summ_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int fv;
    int dn;
    rst = 1'b1;
    start = 1'b1;
    pc = '0;
    end_pc = '0;
    end_pc_en = 1'b0;
    dump_bus.ready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", dump_bus.valid, 0);
    check("rst_idx", dump_bus.idx, 0);
    check("rst_data", dump_bus.data, 0);
    check("rst_final_pc", final_pc, 0);
    check("rst_halt_cause", halt_cause, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_raddr", rf_raddr, 0);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy", busy, 0);

    // End-address halt at 0x40 in RUN cycle 17.
    arm(1, 32'h40, 2'd1, 32'd17);
    run(0, 1, 32'h40, 0, 200, fv, dn);
    check("end_first_valid", fv, 18);
    check("end_done_cycle", dn, 81);
    end_of_dump("end");

    // Re-arm from DONE into a stall halt: 8th equal-PC cycle is RUN cycle 16.
    check("done_before_rearm", done, 1);
    arm(2, 32'h1C, 2'd2, 32'd16);
    run(1, 0, 32'h0, 0, 200, fv, dn);
    check("stall_first_valid", fv, 17);
    check("stall_done_cycle", dn, 80);
    end_of_dump("stall");

    // Watchdog: halt in RUN cycle 1230 with pc = 1229*4.
    arm(3, 32'h1334, 2'd3, 32'd1230);
    run(0, 0, 32'h0, 0, 1500, fv, dn);
    check("wd_first_valid", fv, 1231);
    check("wd_done_cycle", dn, 1294);
    end_of_dump("wd");

    // Backpressure on beat 3, then random ready.
    arm(4, 32'h40, 2'd1, 32'd17);
    run(0, 1, 32'h40, 1, 1000, fv, dn);
    end_of_dump("bp");

    // End address enabled exactly on the stall-limit cycle: end_pc wins.
    arm(5, 32'h1C, 2'd1, 32'd16);
    run(1, 2, 32'h1C, 0, 200, fv, dn);
    check("prio_done_cycle", dn, 80);
    end_of_dump("prio");

    // End address matched in the very first RUN cycle.
    arm(6, 32'h0, 2'd1, 32'd1);
    run(0, 1, 32'h0, 0, 200, fv, dn);
    check("first_first_valid", fv, 2);
    check("first_done_cycle", dn, 65);
    end_of_dump("first");

    // Reset while beat 10 is pending: beats 10..31 never delivered.
    arm(7, 32'h40, 2'd1, 32'd17);
    run(0, 1, 32'h40, 2, 200, fv, dn);
    check("rst_beats_delivered", beats_seen, 10);
    check("rst_beats_pending", beat_q.size(), 22);
    check("rst_no_done", summ_q.size(), 1);
    beat_q.delete();
    summ_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("rst_stays_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
